uart_rx_buf: RTL and testbench

Receive buffer and APB3 register front-end for the UART receiver. It consumes the receiver's byte output (`rx_data` / `rx_flag`) and queues bytes in a DEPTH-entry FIFO. The Cortex-M0 reads them over the peripheral APB bus, and the block raises an interrupt on a fill threshold or on overflow. It sits between the UART RX deserialiser and the APB interconnect.

---
 rtl/uart_rx_buf.sv | 146 ++++++++++++++
 tb/tb_uart_rx_buf.sv | 261 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx_buf.sv
// UART receive FIFO with an APB3 register front-end.
// Bytes are pushed on the rising edge of rx_flag, popped by DATA reads, and an interrupt fires on fill level or overflow.
module uart_rx_buf #(
  parameter int unsigned DEPTH = 16,
  parameter int unsigned AW    = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [7:0]  rx_data,
  input  logic        rx_flag,
  input  logic        psel,
  input  logic        penable,
  input  logic        pwrite,
  input  logic [3:0]  paddr,
  input  logic [31:0] pwdata,
  output logic [31:0] prdata,
  output logic        pready,
  output logic        pslverr,
  output logic        rx_irq
);

  localparam int unsigned CW = AW + 1;

  localparam logic [1:0] ADDR_DATA   = 2'd0;
  localparam logic [1:0] ADDR_STATUS = 2'd1;
  localparam logic [1:0] ADDR_CTRL   = 2'd2;

  logic [7:0]    mem_q [DEPTH];
  logic [AW-1:0] wptr_q, wptr_d;
  logic [AW-1:0] rptr_q, rptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          flag_q;
  logic          ovf_q, ovf_d;
  logic          irq_en_q, irq_en_d;
  logic [AW-1:0] thr_q, thr_d;
  logic          rx_irq_q;

  logic          rd_acc_c, wr_acc_c;
  logic [1:0]    addr_c;
  logic          full_c, empty_c, lvl_c;
  logic          push_req_c, pop_req_c, flush_c, ovf_clr_c;
  logic          do_push_c, do_pop_c, ovf_set_c;
  logic          unused_c;

  assign pready  = 1'b1;
  assign pslverr = 1'b0;
  assign rx_irq  = rx_irq_q;

  assign rd_acc_c = psel & penable & ~pwrite;
  assign wr_acc_c = psel & penable & pwrite;
  assign addr_c   = paddr[3:2];
  assign unused_c = ^{pwdata, paddr[1:0]};

  assign full_c  = (count_q == CW'(DEPTH));
  assign empty_c = (count_q == CW'(0));
  assign lvl_c   = (count_q > {1'b0, thr_q});

  assign push_req_c = rx_flag & ~flag_q;
  assign pop_req_c  = rd_acc_c & (addr_c == ADDR_DATA) & ~empty_c;
  assign flush_c    = wr_acc_c & (addr_c == ADDR_CTRL) & pwdata[1];
  assign ovf_clr_c  = wr_acc_c & (addr_c == ADDR_STATUS) & pwdata[2];

  // Flush overrides everything; a pop in the same cycle frees the slot for a push at full.
  assign do_push_c = push_req_c & (~full_c | pop_req_c) & ~flush_c;
  assign do_pop_c  = pop_req_c & ~flush_c;
  assign ovf_set_c = push_req_c & full_c & ~pop_req_c & ~flush_c;

  // Next-state for pointers, count and control registers
  always_comb begin
    wptr_d   = wptr_q;
    rptr_d   = rptr_q;
    count_d  = count_q;
    ovf_d    = (ovf_q & ~ovf_clr_c) | ovf_set_c;
    irq_en_d = irq_en_q;
    thr_d    = thr_q;
    if (flush_c) begin
      wptr_d  = '0;
      rptr_d  = '0;
      count_d = '0;
    end else begin
      if (do_push_c) wptr_d = wptr_q + AW'(1);
      if (do_pop_c)  rptr_d = rptr_q + AW'(1);
      case ({do_push_c, do_pop_c})
        2'b10:   count_d = count_q + CW'(1);
        2'b01:   count_d = count_q - CW'(1);
        default: count_d = count_q;
      endcase
    end
    if (wr_acc_c && (addr_c == ADDR_CTRL)) begin
      irq_en_d = pwdata[0];
      thr_d    = pwdata[4+AW-1:4];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr_q   <= '0;
      rptr_q   <= '0;
      count_q  <= '0;
      flag_q   <= 1'b0;
      ovf_q    <= 1'b0;
      irq_en_q <= 1'b0;
      thr_q    <= '0;
      rx_irq_q <= 1'b0;
    end else begin
      wptr_q   <= wptr_d;
      rptr_q   <= rptr_d;
      count_q  <= count_d;
      flag_q   <= rx_flag;
      ovf_q    <= ovf_d;
      irq_en_q <= irq_en_d;
      thr_q    <= thr_d;
      rx_irq_q <= irq_en_q & (lvl_c | ovf_q);
    end
  end

  // Storage array carries no reset; contents are qualified by count
  always_ff @(posedge clk) begin
    if (do_push_c) mem_q[wptr_q] <= rx_data;
  end

  // Read mux, driven only during a read access phase
  always_comb begin
    prdata = 32'h0;
    if (rd_acc_c) begin
      case (addr_c)
        ADDR_DATA: begin
          if (!empty_c) prdata[7:0] = mem_q[rptr_q];
        end
        ADDR_STATUS: begin
          prdata[0]      = empty_c;
          prdata[1]      = full_c;
          prdata[2]      = ovf_q;
          prdata[3]      = lvl_c;
          prdata[8+AW:8] = count_q;
        end
        ADDR_CTRL: begin
          prdata[0]        = irq_en_q;
          prdata[4+AW-1:4] = thr_q;
        end
        default: prdata = 32'h0;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_rx_buf.sv
// Self-checking bench for uart_rx_buf: scoreboard queue of expected bytes plus a small status model.
module tb_uart_rx_buf;

  localparam int unsigned DEPTH = 16;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [7:0]  rx_data = 8'h0;
  logic        rx_flag = 1'b0;
  logic        psel = 1'b0;
  logic        penable = 1'b0;
  logic        pwrite = 1'b0;
  logic [3:0]  paddr = 4'h0;
  logic [31:0] pwdata = 32'h0;
  logic [31:0] prdata;
  logic        pready;
  logic        pslverr;
  logic        rx_irq;

  int pass_cnt = 0;
  int tot_cnt  = 0;

  logic [7:0] q_exp[$];
  logic       m_ovf = 1'b0;
  logic [3:0] m_thr = 4'h0;

  uart_rx_buf #(.DEPTH(16), .AW(4)) dut (
    .clk(clk), .rst_n(rst_n), .rx_data(rx_data), .rx_flag(rx_flag),
    .psel(psel), .penable(penable), .pwrite(pwrite), .paddr(paddr),
    .pwdata(pwdata), .prdata(prdata), .pready(pready), .pslverr(pslverr),
    .rx_irq(rx_irq)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  function automatic logic [31:0] exp_status();
    logic [31:0] s;
    int c;
    c = q_exp.size();
    s = 32'h0;
    s[0] = (c == 0);
    s[1] = (c == DEPTH);
    s[2] = m_ovf;
    s[3] = (c > int'(m_thr));
    s[12:8] = 5'(c);
    return s;
  endfunction

  task automatic apb_read(input logic [3:0] a, output logic [31:0] d);
    @(negedge clk);
    psel = 1'b1; penable = 1'b0; pwrite = 1'b0; paddr = a;
    @(negedge clk);
    penable = 1'b1;
    #1 d = prdata;
    @(negedge clk);
    psel = 1'b0; penable = 1'b0;
  endtask

  task automatic apb_write(input logic [3:0] a, input logic [31:0] v);
    @(negedge clk);
    psel = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = a; pwdata = v;
    @(negedge clk);
    penable = 1'b1;
    @(negedge clk);
    psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
  endtask

  task automatic push_byte(input logic [7:0] b);
    @(negedge clk);
    rx_data = b; rx_flag = 1'b1;
    if (q_exp.size() == DEPTH) m_ovf = 1'b1;
    else q_exp.push_back(b);
    @(negedge clk);
    rx_flag = 1'b0;
    @(negedge clk);
  endtask

  task automatic read_check_data(input string nm);
    logic [31:0] d;
    logic [31:0] e;
    apb_read(4'h0, d);
    e = (q_exp.size() == 0) ? 32'h0 : {24'h0, q_exp.pop_front()};
    tot_cnt++;
    if (d !== e) $display("FAIL %s: got %08h expected %08h", nm, d, e);
    else pass_cnt++;
  endtask

  task automatic read_check_status(input string nm);
    logic [31:0] d;
    logic [31:0] e;
    apb_read(4'h4, d);
    e = exp_status();
    tot_cnt++;
    if (d !== e) $display("FAIL %s: got %08h expected %08h", nm, d, e);
    else pass_cnt++;
  endtask

  task automatic test_reset();
    logic [31:0] d;
    #3;
    tot_cnt++;
    if ({rx_irq, prdata, pready, pslverr} !== {1'b0, 32'h0, 1'b1, 1'b0})
      $display("FAIL reset_outputs: got irq=%b prdata=%08h rdy=%b err=%b expected 0/0/1/0",
               rx_irq, prdata, pready, pslverr);
    else pass_cnt++;
    @(negedge clk);
    rst_n = 1'b1;
    read_check_status("reset_status");
    apb_read(4'h8, d);
    tot_cnt++;
    if (d !== 32'h0) $display("FAIL reset_ctrl: got %08h expected 00000000", d);
    else pass_cnt++;
  endtask

  task automatic test_single_byte();
    apb_write(4'h8, 32'h01);
    m_thr = 4'h0;
    @(negedge clk);
    rx_data = 8'hA5; rx_flag = 1'b1;
    q_exp.push_back(8'hA5);
    @(negedge clk);
    tot_cnt++;
    if (rx_irq !== 1'b0) $display("FAIL single_irq_t: got %b expected 0", rx_irq);
    else pass_cnt++;
    @(negedge clk);
    tot_cnt++;
    if (rx_irq !== 1'b1) $display("FAIL single_irq_t1: got %b expected 1", rx_irq);
    else pass_cnt++;
    repeat (18) @(negedge clk);
    read_check_status("single_status_held");
    rx_flag = 1'b0;
    read_check_data("single_data");
    read_check_status("single_status_empty");
    tot_cnt++;
    if (rx_irq !== 1'b0) $display("FAIL single_irq_drop: got %b expected 0", rx_irq);
    else pass_cnt++;
  endtask

  task automatic test_fill_overflow();
    for (int i = 0; i <= 16; i++) push_byte(8'(i));
    read_check_status("fill_status_full_ovf");
    for (int i = 0; i < 16; i++) read_check_data("fill_data");
    read_check_status("fill_status_drained");
    apb_write(4'h4, 32'h4);
    m_ovf = 1'b0;
    read_check_status("fill_ovf_clear");
  endtask

  task automatic test_threshold();
    apb_write(4'h8, 32'h31);
    m_thr = 4'h3;
    for (int i = 0; i < 3; i++) push_byte(8'h40 + 8'(i));
    repeat (2) @(negedge clk);
    tot_cnt++;
    if (rx_irq !== 1'b0) $display("FAIL thr_irq_3: got %b expected 0", rx_irq);
    else pass_cnt++;
    push_byte(8'h43);
    tot_cnt++;
    if (rx_irq !== 1'b1) $display("FAIL thr_irq_4: got %b expected 1", rx_irq);
    else pass_cnt++;
    read_check_data("thr_pop");
    @(negedge clk);
    tot_cnt++;
    if (rx_irq !== 1'b0) $display("FAIL thr_irq_pop: got %b expected 0", rx_irq);
    else pass_cnt++;
    for (int i = 0; i < 3; i++) read_check_data("thr_drain");
  endtask

  task automatic test_full_simul();
    logic [31:0] d;
    logic [31:0] e;
    apb_write(4'h8, 32'h01);
    m_thr = 4'h0;
    for (int i = 0; i < 16; i++) push_byte(8'h20 + 8'(i));
    @(negedge clk);
    psel = 1'b1; penable = 1'b0; pwrite = 1'b0; paddr = 4'h0;
    @(negedge clk);
    penable = 1'b1; rx_data = 8'h77; rx_flag = 1'b1;
    #1 d = prdata;
    e = {24'h0, q_exp.pop_front()};
    q_exp.push_back(8'h77);
    tot_cnt++;
    if (d !== e) $display("FAIL simul_read: got %08h expected %08h", d, e);
    else pass_cnt++;
    @(negedge clk);
    psel = 1'b0; penable = 1'b0; rx_flag = 1'b0;
    read_check_status("simul_status");
    for (int i = 0; i < 16; i++) read_check_data("simul_data");
  endtask

  task automatic test_empty_flush();
    logic [31:0] d;
    read_check_data("empty_read");
    read_check_status("empty_status");
    for (int i = 0; i < 5; i++) push_byte(8'h60 + 8'(i));
    read_check_status("flush_pre_status");
    @(negedge clk);
    psel = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = 4'h8; pwdata = 32'h02;
    @(negedge clk);
    penable = 1'b1; rx_data = 8'h99; rx_flag = 1'b1;
    @(negedge clk);
    psel = 1'b0; penable = 1'b0; pwrite = 1'b0; rx_flag = 1'b0;
    q_exp.delete();
    m_thr = 4'h0;
    read_check_status("flush_status");
    apb_read(4'h8, d);
    tot_cnt++;
    if (d !== 32'h0) $display("FAIL flush_ctrl: got %08h expected 00000000", d);
    else pass_cnt++;
  endtask

  task automatic test_reset_mid();
    logic [31:0] d;
    apb_write(4'h8, 32'h01);
    for (int i = 0; i < 17; i++) push_byte(8'h80 + 8'(i));
    read_check_status("mid_pre_status");
    tot_cnt++;
    if (rx_irq !== 1'b1) $display("FAIL mid_pre_irq: got %b expected 1", rx_irq);
    else pass_cnt++;
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    tot_cnt++;
    if (rx_irq !== 1'b0) $display("FAIL mid_async_irq: got %b expected 0", rx_irq);
    else pass_cnt++;
    @(negedge clk);
    rst_n = 1'b1;
    q_exp.delete();
    m_ovf = 1'b0;
    m_thr = 4'h0;
    read_check_status("mid_status");
    apb_read(4'h8, d);
    tot_cnt++;
    if (d !== 32'h0) $display("FAIL mid_ctrl: got %08h expected 00000000", d);
    else pass_cnt++;
    apb_read(4'hC, d);
    tot_cnt++;
    if (d !== 32'h0) $display("FAIL reserved_read: got %08h expected 00000000", d);
    else pass_cnt++;
  endtask

  initial begin
    test_reset();
    test_single_byte();
    test_fill_overflow();
    test_threshold();
    test_full_simul();
    test_empty_flush();
    test_reset_mid();
    repeat (2) @(negedge clk);
    $display("%0d/%0d checks passed", pass_cnt, tot_cnt);
    $finish;
  end

endmodule
